// File: rtl/ctrl_pkg.sv
// Shared definitions for the ALU/mux/register-file sequencers.
// Control word: [15]=0, [14:13] ALU op, [12:9] mux A, [8:5] mux B, [4:1] dest reg, [0] write enable.
package ctrl_pkg;

    localparam int unsigned CW_W     = 16;

    localparam int unsigned ALU_LSB  = 13;
    localparam int unsigned ALU_W    = 2;
    localparam int unsigned MUXA_LSB = 9;
    localparam int unsigned MUXB_LSB = 5;
    localparam int unsigned MUX_W    = 4;
    localparam int unsigned REG_LSB  = 1;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned WE_LSB   = 0;

    typedef enum logic [ALU_W-1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10,
        ALU_SHL  = 2'b11
    } alu_op_t;

    localparam logic [REG_W-1:0] R0 = 4'd0;
    localparam logic [REG_W-1:0] R1 = 4'd1;
    localparam logic [REG_W-1:0] R2 = 4'd2;
    localparam logic [REG_W-1:0] R3 = 4'd3;
    localparam logic [REG_W-1:0] R4 = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CHK  = 3'd1,
        S_CLR  = 3'd2,
        S_SHL1 = 3'd3,
        S_SHL0 = 3'd4,
        S_SUB  = 3'd5,
        S_FIX  = 3'd6,
        S_FIN  = 3'd7
    } div_state_t;

    function automatic logic [CW_W-1:0] mk_word(
        input alu_op_t          op,
        input logic [MUX_W-1:0] a,
        input logic [MUX_W-1:0] b,
        input logic [REG_W-1:0] dst,
        input logic             we
    );
        logic [CW_W-1:0] w;
        w = '0;
        w[ALU_LSB  +: ALU_W] = op;
        w[MUXA_LSB +: MUX_W] = a;
        w[MUXB_LSB +: MUX_W] = b;
        w[REG_LSB  +: REG_W] = dst;
        w[WE_LSB]            = we;
        return w;
    endfunction

    localparam logic [CW_W-1:0] W_IDLE    = '0;
    localparam logic [CW_W-1:0] W_CHK     = mk_word(ALU_PASS, R2, R0, R0, 1'b0);
    localparam logic [CW_W-1:0] W_CLR     = mk_word(ALU_PASS, R3, R0, R1, 1'b1);
    localparam logic [CW_W-1:0] W_SHL1    = mk_word(ALU_SHL,  R1, R0, R1, 1'b1);
    localparam logic [CW_W-1:0] W_SHL0    = mk_word(ALU_SHL,  R0, R3, R0, 1'b1);
    localparam logic [CW_W-1:0] W_SUB     = mk_word(ALU_SUB,  R1, R2, R1, 1'b1);
    localparam logic [CW_W-1:0] W_RESTORE = mk_word(ALU_ADD,  R1, R2, R1, 1'b1);
    localparam logic [CW_W-1:0] W_SETQ    = mk_word(ALU_ADD,  R0, R4, R0, 1'b1);

endpackage

// File: rtl/ctrl_iter_cnt.sv
// Iteration counter for shift-based sequencers: synchronous clear/enable,
// saturates at LAST and flags terminal count.
module ctrl_iter_cnt #(
    parameter int unsigned     CNT_W = 3,
    parameter logic [CNT_W-1:0] LAST = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/control_div.sv
// Restoring-division sequencer for the shared datapath: quotient in R0, remainder in R1.
// Start/busy/done handshake with divide-by-zero detection on the divisor in R2.
module control_div
    import ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signo,
    input  logic            div_cero,
    output logic [CW_W-1:0] o_signal,
    output logic            busy,
    output logic            done,
    output logic            err
);

    div_state_t r_state;
    logic       r_err;
    logic       w_start_ok;
    logic       w_tc;

    assign w_start_ok = (r_state == S_IDLE) && start;

    ctrl_iter_cnt #(
        .CNT_W (CNT_W),
        .LAST  (CNT_W'(WIDTH - 1))
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_start_ok),
        .i_en  (r_state == S_FIX),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CHK;
                        r_err   <= 1'b0;
                    end
                end
                S_CHK: begin
                    if (div_cero) begin
                        r_state <= S_FIN;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= S_CLR;
                    end
                end
                S_CLR:   r_state <= S_SHL1;
                S_SHL1:  r_state <= S_SHL0;
                S_SHL0:  r_state <= S_SUB;
                S_SUB:   r_state <= S_FIX;
                S_FIX:   r_state <= w_tc ? S_FIN : S_SHL1;
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIX is the only Mealy state: restore vs. set-quotient-bit follows the borrow flag.
    always_comb begin
        o_signal = W_IDLE;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_CHK:  begin o_signal = W_CHK;  busy = 1'b1; end
            S_CLR:  begin o_signal = W_CLR;  busy = 1'b1; end
            S_SHL1: begin o_signal = W_SHL1; busy = 1'b1; end
            S_SHL0: begin o_signal = W_SHL0; busy = 1'b1; end
            S_SUB:  begin o_signal = W_SUB;  busy = 1'b1; end
            S_FIX:  begin
                o_signal = signo ? W_RESTORE : W_SETQ;
                busy     = 1'b1;
            end
            S_FIN:  done = 1'b1;
            default: o_signal = W_IDLE;
        endcase
    end

    assign err = r_err;

endmodule
